// File: rtl/switch_poll_ctrl.sv
// switch_poll_ctrl: periodic switch poller with debounce, edge capture, irq and a CPU register port (optional debounce: SWITCH_POLL_DEBOUNCE_EN)
module switch_poll_ctrl #(
    parameter int WIDTH          = 18,
    parameter int DEBOUNCE_COUNT = 4,
    parameter int PERIOD_RESET   = 50000
) (
    input  logic             clk,
    input  logic             reset,
    output logic [1:0]       sw_address,
    input  logic [WIDTH-1:0] sw_readdata,
    input  logic [1:0]       s_address,
    input  logic             s_read,
    input  logic             s_write,
    input  logic [31:0]      s_writedata,
    output logic [31:0]      s_readdata,
    output logic             irq
);
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, UPDATE} state_t;

    state_t           state;
    logic [15:0]      timer;
    logic [15:0]      period;
    logic [15:0]      reload;
    logic [WIDTH-1:0] sample;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_nxt;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] wr_clr;
    logic [31:0]      rd_mux;
    logic             unused_wd;

    assign reload    = (period == 16'd0) ? 16'd0 : period - 16'd1;
    assign wr_clr    = (s_write && s_address == 2'd1) ? s_writedata[WIDTH-1:0] : '0;
    assign irq       = |(edge_capture & irq_mask);
    assign unused_wd = ^s_writedata;

`ifdef SWITCH_POLL_DEBOUNCE_EN
    logic [WIDTH-1:0] candidate;
    logic [WIDTH-1:0] cand_nxt;
    logic [3:0]       count;
    logic [3:0]       count_nxt;

    // Track how long the latest sample has persisted and promote it once seen often enough
    always_comb begin
        cand_nxt   = candidate;
        count_nxt  = count;
        stable_nxt = stable;
        if (state == UPDATE) begin
            cand_nxt   = sample;
            count_nxt  = (sample != candidate) ? 4'd1 : (count == 4'(DEBOUNCE_COUNT)) ? count : count + 4'd1;
            stable_nxt = (count_nxt == 4'(DEBOUNCE_COUNT)) ? cand_nxt : stable;
        end
    end

    // Debounce candidate and its saturating match count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            candidate <= '0;
            count     <= '0;
        end else begin
            candidate <= cand_nxt;
            count     <= count_nxt;
        end
    end
`else
    assign stable_nxt = (state == UPDATE) ? sample : stable;
`endif

    // Poll sequencer: wait out the period, present address 0, capture the data, then publish it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            timer      <= 16'(PERIOD_RESET - 1);
            sw_address <= 2'b11;
            sample     <= '0;
            stable     <= '0;
        end else begin
            stable <= stable_nxt;
            case (state)
                IDLE: begin
                    timer      <= (timer == 16'd0) ? reload : timer - 16'd1;
                    state      <= (timer == 16'd0) ? ISSUE : IDLE;
                    sw_address <= (timer == 16'd0) ? 2'b00 : 2'b11;
                end
                ISSUE: begin
                    state      <= CAPTURE;
                    sw_address <= 2'b11;
                end
                CAPTURE: begin
                    state  <= UPDATE;
                    sample <= sw_readdata;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read mux always reflects register contents before any same-cycle write
    always_comb
        rd_mux = (s_address == 2'd0) ? 32'(stable) :
                 (s_address == 2'd1) ? 32'(edge_capture) :
                 (s_address == 2'd2) ? 32'(irq_mask) : {16'd0, period};

    // CPU registers; a fresh edge wins over a same-cycle write-1-to-clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_capture <= '0;
            irq_mask     <= '0;
            period       <= 16'(PERIOD_RESET);
            s_readdata   <= '0;
        end else begin
            edge_capture <= (edge_capture & ~wr_clr) | (stable ^ stable_nxt);
            if (s_write && s_address == 2'd2) irq_mask <= s_writedata[WIDTH-1:0];
            if (s_write && s_address == 2'd3) period <= s_writedata[15:0];
            if (s_read) s_readdata <= rd_mux;
        end
    end
endmodule

// File: tb/tb_switch_poll_ctrl.sv
// tb_switch_poll_ctrl: randomized bench for switch_poll_ctrl against a sample-history reference model
module tb_switch_poll_ctrl;
    localparam int W  = 18;
    localparam int N  = 4;
    localparam int PR = 20;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [1:0]   sw_address;
    logic [W-1:0] sw_readdata = '0;
    logic [W-1:0] in_port = '0;
    logic [1:0]   s_address = 2'd0;
    logic         s_read = 1'b0;
    logic         s_write = 1'b0;
    logic [31:0]  s_writedata = 32'd0;
    logic [31:0]  s_readdata;
    logic         irq;

    int vectors = 0;
    int miscompares = 0;

    logic [W-1:0] hist[$];
    logic [W-1:0] m_stable = '0;
    logic [W-1:0] m_edge = '0;
    logic [W-1:0] m_mask = '0;
    logic [15:0]  m_period = 16'(PR);
    logic [W-1:0] pend_v = '0;
    logic [W-1:0] nv;
    bit           same;
    int           pend = 0;

    switch_poll_ctrl #(.WIDTH(W), .DEBOUNCE_COUNT(N), .PERIOD_RESET(PR)) dut (
        .clk(clk), .reset(reset), .sw_address(sw_address), .sw_readdata(sw_readdata),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_readdata(s_readdata), .irq(irq)
    );

    always #5 clk = ~clk;

    // Switch PIO slave: registered data the cycle after address 0
    always @(posedge clk) if (sw_address == 2'd0) sw_readdata <= in_port;

    // Reference model: a poll's value lands two cycles after the slave grabs it; stable follows
    // the value once the last N polls agree (or every poll without debounce)
    always @(posedge clk) begin
        if (reset) begin
            hist.delete();
            m_stable = '0;
            m_edge   = '0;
            m_mask   = '0;
            m_period = 16'(PR);
            pend     = 0;
        end else begin
            if (s_write && s_address == 2'd1) m_edge = m_edge & ~s_writedata[W-1:0];
            if (s_write && s_address == 2'd2) m_mask = s_writedata[W-1:0];
            if (s_write && s_address == 2'd3) m_period = s_writedata[15:0];
            if (pend == 1) begin
                hist.push_back(pend_v);
                if (hist.size() > 16) void'(hist.pop_front());
                nv = pend_v;
`ifdef SWITCH_POLL_DEBOUNCE_EN
                nv = m_stable;
                if (hist.size() >= N) begin
                    same = 1'b1;
                    for (int k = 0; k < N; k++) if (hist[hist.size() - 1 - k] != pend_v) same = 1'b0;
                    if (same) nv = pend_v;
                end
`endif
                m_edge   = m_edge | (m_stable ^ nv);
                m_stable = nv;
            end
            if (pend != 0) pend--;
            if (sw_address == 2'd0) begin
                pend_v = in_port;
                pend   = 2;
            end
        end
    end

    function automatic logic [31:0] model_reg(input int a);
        case (a)
            0: return 32'(m_stable);
            1: return 32'(m_edge);
            2: return 32'(m_mask);
            default: return {16'd0, m_period};
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cpu_read(input logic [1:0] a, output logic [31:0] d);
        s_address = a;
        s_read = 1'b1;
        @(negedge clk);
        s_read = 1'b0;
        d = s_readdata;
    endtask

    task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
        s_address = a;
        s_writedata = d;
        s_write = 1'b1;
        @(negedge clk);
        s_write = 1'b0;
    endtask

    task automatic wait_issue(output int cyc);
        cyc = 0;
        while (sw_address !== 2'b00 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        if (sw_address !== 2'b00) begin
            vectors++;
            miscompares++;
            cyc = -1;
            $display("FAIL wait_issue: no poll seen within 400 cycles");
        end
    endtask

    task automatic do_poll(input logic [W-1:0] v);
        int c;
        in_port = v;
        wait_issue(c);
        tick(3);
    endtask

    task automatic test_reset;
        int c;
        logic [31:0] d;
        in_port = '0;
        reset = 1'b1;
        tick(2);
        vectors++;
        if (sw_address !== 2'b11 || irq !== 1'b0 || s_readdata !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: sw_address=%b irq=%b s_readdata=%h, want 11 0 00000000", sw_address, irq, s_readdata);
        end
        reset = 1'b0;
        wait_issue(c);
        vectors++;
        if (c != PR) begin
            miscompares++;
            $display("FAIL first_poll_delay: got %0d cycles, want %0d", c, PR);
        end
        for (int a = 0; a < 4; a++) begin
            cpu_read(2'(a), d);
            vectors++;
            if (d !== ((a == 3) ? 32'(PR) : 32'd0)) begin
                miscompares++;
                $display("FAIL reset_reg%0d: got %h want %h", a, d, (a == 3) ? 32'(PR) : 32'd0);
            end
        end
    endtask

    task automatic test_cadence;
        int c;
        cpu_write(2'd3, 32'd10);
        wait_issue(c);
        tick(1);
        wait_issue(c);
        vectors++;
        if (c + 1 != 13) begin
            miscompares++;
            $display("FAIL cadence_p10: got %0d cycles, want 13", c + 1);
        end
        cpu_write(2'd3, 32'd0);
        wait_issue(c);
        tick(1);
        wait_issue(c);
        vectors++;
        if (c + 1 != 4) begin
            miscompares++;
            $display("FAIL cadence_p0: got %0d cycles, want 4", c + 1);
        end
        cpu_write(2'd3, 32'd10);
        wait_issue(c);
        tick(3);
    endtask

    task automatic test_debounce;
        logic [31:0] d;
        for (int p = 1; p <= 4; p++) begin
            do_poll(18'h2A5A5);
            cpu_read(2'd0, d);
            vectors++;
            if (d !== model_reg(0)) begin
                miscompares++;
                $display("FAIL debounce_poll%0d: stable got %h want %h", p, d, model_reg(0));
            end
        end
        cpu_read(2'd0, d);
        vectors++;
        if (d !== 32'h2A5A5) begin
            miscompares++;
            $display("FAIL debounce_stable: got %h want 0002a5a5", d);
        end
        cpu_read(2'd1, d);
        vectors++;
        if (d !== 32'h2A5A5 || irq !== 1'b0) begin
            miscompares++;
            $display("FAIL debounce_edge: edge got %h irq %b, want 0002a5a5 0", d, irq);
        end
    endtask

    task automatic test_glitch(input int b);
        logic [31:0] d;
        logic [W-1:0] base;
        base = in_port;
        cpu_write(2'd2, 32'(W'(1) << b));
        cpu_write(2'd1, 32'hFFFF_FFFF);
        for (int p = 0; p < 3; p++) begin
            do_poll((p == 0) ? base ^ (W'(1) << b) : base);
            for (int a = 0; a < 2; a++) begin
                cpu_read(2'(a), d);
                vectors++;
                if (d !== model_reg(a)) begin
                    miscompares++;
                    $display("FAIL glitch_b%0d_poll%0d_reg%0d: got %h want %h", b, p, a, d, model_reg(a));
                end
            end
            vectors++;
            if (irq !== |(m_edge & m_mask)) begin
                miscompares++;
                $display("FAIL glitch_b%0d_irq: got %b want %b", b, irq, |(m_edge & m_mask));
            end
        end
    endtask

    task automatic test_irq_w1c;
        logic [31:0] d;
        logic [W-1:0] base;
        cpu_write(2'd2, 32'h3FFFF);
        cpu_write(2'd1, 32'h3FFFF);
        base = in_port ^ W'(1);
        repeat (4) do_poll(base);
        cpu_read(2'd1, d);
        vectors++;
        if (d[0] !== 1'b1 || irq !== 1'b1 || d !== model_reg(1)) begin
            miscompares++;
            $display("FAIL irq_set: edge got %h irq %b, want %h 1", d, irq, model_reg(1));
        end
        cpu_write(2'd1, 32'd1);
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++;
            $display("FAIL irq_clear: irq got %b want 0", irq);
        end
    endtask

    task automatic test_collision;
        int c;
        logic [31:0] d;
        logic [W-1:0] base;
        cpu_write(2'd1, 32'hFFFF_FFFF);
        base = in_port ^ W'(1);
`ifdef SWITCH_POLL_DEBOUNCE_EN
        repeat (N - 1) do_poll(base);
`endif
        in_port = base;
        wait_issue(c);
        tick(2);
        cpu_write(2'd1, 32'd1);
        cpu_read(2'd1, d);
        vectors++;
        if (d[0] !== 1'b1 || d !== model_reg(1)) begin
            miscompares++;
            $display("FAIL w1c_collision: edge got %h want %h with bit0 set", d, model_reg(1));
        end
    endtask

    task automatic test_sim_rw;
        logic [31:0] d;
        logic [31:0] old_m;
        logic [31:0] new_m;
        old_m = model_reg(2);
        new_m = 32'($urandom) & 32'h3FFFF;
        s_address = 2'd2;
        s_writedata = new_m;
        s_write = 1'b1;
        s_read = 1'b1;
        @(negedge clk);
        s_write = 1'b0;
        s_read = 1'b0;
        vectors++;
        if (s_readdata !== old_m) begin
            miscompares++;
            $display("FAIL rw_same_cycle: got %h want %h", s_readdata, old_m);
        end
        cpu_read(2'd2, d);
        vectors++;
        if (d !== new_m) begin
            miscompares++;
            $display("FAIL rw_after: got %h want %h", d, new_m);
        end
    endtask

    task automatic test_random;
        logic [31:0] d;
        logic [W-1:0] v;
        int n;
        cpu_write(2'd2, 32'($urandom) & 32'h3FFFF);
        for (int i = 0; i < 8; i++) begin
            v = W'($urandom);
            if (i % 3 == 1) v = in_port ^ (W'(1) << $urandom_range(0, W - 1));
            n = $urandom_range(1, 5);
            for (int p = 0; p < n; p++) begin
                do_poll(v);
                for (int a = 0; a < 2; a++) begin
                    cpu_read(2'(a), d);
                    vectors++;
                    if (d !== model_reg(a)) begin
                        miscompares++;
                        $display("FAIL random_i%0d_p%0d_reg%0d: got %h want %h", i, p, a, d, model_reg(a));
                    end
                end
                vectors++;
                if (irq !== |(m_edge & m_mask)) begin
                    miscompares++;
                    $display("FAIL random_irq_i%0d: got %b want %b", i, irq, |(m_edge & m_mask));
                end
                if (p == 1) cpu_write(2'd1, $urandom);
            end
        end
    endtask

    task automatic test_reset_mid;
        int c;
        in_port = W'($urandom) | W'(1);
        wait_issue(c);
        tick(1);
        test_reset;
    endtask

    initial begin
        test_reset;
        test_cadence;
        test_debounce;
        test_glitch(0);
        test_irq_w1c;
        test_collision;
        test_sim_rw;
        test_random;
        test_glitch(5);
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/switch_poll_ctrl.md
SWITCH_POLL_CTRL -- requirements
Module: switch_poll_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 18, switch bus width.
REQ-002 SHALL have parameter DEBOUNCE_COUNT, default 4, number of identical consecutive samples required to accept a value (legal range 2..15).
REQ-003 SHALL have parameter PERIOD_RESET, default 50000, reset value of the poll period register in clk cycles.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port sw_address  output  2  address to the switch PIO slave.
REQ-007 SHALL have port sw_readdata  input  WIDTH  registered read data from the switch PIO slave, valid the cycle after address 0 is presented.
REQ-008 SHALL have port s_address  input  2  CPU slave register select.
REQ-009 SHALL have ports s_read and s_write  input  1 each  CPU read and write strobes.
REQ-010 SHALL have port s_writedata  input  32  CPU write data.
REQ-011 SHALL have port s_readdata  output  32  CPU read data, registered.
REQ-012 SHALL have port irq  output  1  level interrupt to the CPU.

Function
REQ-013 SHALL implement an FSM with states IDLE, ISSUE, CAPTURE and UPDATE.
REQ-014 IDLE SHALL count down a 16-bit timer and go to ISSUE when the timer is 0; on leaving IDLE the timer SHALL reload with period-1 (period 0 treated as 1).
REQ-015 ISSUE SHALL drive sw_address=0 for exactly one cycle; in all other states sw_address SHALL be 2'b11.
REQ-016 CAPTURE SHALL latch sw_readdata into the sample register; UPDATE SHALL run the debounce/edge logic and return to IDLE.
REQ-017 Poll cadence SHALL be one sample every max(period,1)+3 cycles.
REQ-018 Debounce: sample==candidate SHALL increment a saturating match count; a mismatch SHALL load candidate<=sample and reset the count to 1 sample.
REQ-019 When the count reaches DEBOUNCE_COUNT and candidate!=stable, stable SHALL load candidate in the UPDATE cycle.
REQ-020 Every stable change SHALL OR (old stable XOR new stable) into edge_capture.
REQ-021 Register map (s_address): 0 stable (RO, zero-extended); 1 edge_capture (write-1-to-clear); 2 irq_mask (RW, WIDTH bits); 3 period (RW, low 16 bits).
REQ-022 s_readdata SHALL update the cycle after s_read with 1-cycle latency and hold its value otherwise; unused bits SHALL read 0.
REQ-023 A write to period SHALL take effect at the next timer reload and SHALL NOT abort a poll in progress.
REQ-024 When a W1C clear and a new edge hit the same bit in the same cycle, the set SHALL win.
REQ-025 irq SHALL equal OR-reduce(edge_capture & irq_mask), driven from registers with no combinational path from the s_ ports.
REQ-026 Simultaneous s_read and s_write SHALL perform both operations; the read SHALL return the pre-write value.

Reset
REQ-027 Reset SHALL force state=IDLE, timer=PERIOD_RESET-1, period=PERIOD_RESET, stable=0, candidate=0, count=0, edge_capture=0, irq_mask=0, s_readdata=0, sw_address=2'b11 and irq=0.
REQ-028 Reset asserted mid-poll SHALL discard the sample in flight; after release the first poll SHALL occur PERIOD_RESET cycles later.

Configuration
REQ-029 With macro SWITCH_POLL_DEBOUNCE_EN defined, debounce SHALL operate per REQ-018/019.
REQ-030 Without SWITCH_POLL_DEBOUNCE_EN, UPDATE SHALL load stable<=sample directly, and the candidate and count registers SHALL NOT be built.

Verification
REQ-031 Set period=10 and hold in_port at 0x2A5A5 -> with debounce, stable=0x2A5A5 after the 4th poll; edge_capture=0x2A5A5; irq stays 0 while mask=0.
REQ-032 Set mask=0x00001 and toggle bit0 for a single poll -> stable, edge_capture and irq are unchanged.
REQ-033 Set mask=0x3FFFF and hold a bit0 change for 4 polls -> edge_capture[0]=1 and irq=1; writing 1 to addr 1 clears it and irq drops the next cycle.
REQ-034 Issue a W1C of bit0 in the same cycle as a new bit0 edge -> edge_capture[0] remains 1.
REQ-035 Assert reset during CAPTURE -> all registers return to reset values; the next ISSUE comes PERIOD_RESET cycles after release.
REQ-036 Build without SWITCH_POLL_DEBOUNCE_EN and apply a one-poll glitch on bit5 -> stable[5] follows the glitch and edge_capture[5]=1.
